// File: rtl/split_slave.sv
// split_slave: split-capable single-beat memory slave on the two-master bus.
//
// Serves reads and writes to a local 2^ADDR_W x DATA_W memory. Writes complete
// with a one-cycle wack. Reads either complete in one cycle (SPLIT_LAT == 0) or
// are answered with a split: ssplit is held high for SPLIT_LAT cycles while the
// backend latency elapses. ssplit then drops so the arbiter re-grants the split
// owner. Data is returned in the cycle after the split_grant pulse.
//
// Handshake: a request is accepted at a rising edge only when the slave is
// idle (sready = 1) and sel && req_valid are both high. Requests seen in any
// other state are dropped without queueing or error. rvalid and wack are
// single-cycle strobes, and the two are never high together.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   sel, req_valid      decoder select and request strobe
//   req_write           1 = write, 0 = read
//   req_addr, req_wdata word address and write data
//   split_grant         arbiter pulse that permits a split read to complete
//   sready              idle and able to accept (to arbiter sreadysp)
//   ssplit              split in progress (to arbiter ssplit)
//   rdata, rvalid       read data and its one-cycle strobe
//   wack                one-cycle write acknowledge
module split_slave #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 8,
    parameter int SPLIT_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              split_grant,
    output logic              sready,
    output logic              ssplit,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              wack
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WACK   = 3'd1,
        RFAST  = 3'd2,
        SPLIT  = 3'd3,
        RESUME = 3'd4,
        RESP   = 3'd5
    } state_t;

    // The counter is loaded with SPLIT_LAT-1 and counts down to 0. This gives
    // exactly SPLIT_LAT cycles in SPLIT.
    localparam logic [7:0] CNT_LOAD = (SPLIT_LAT == 0) ? 8'd0 : 8'(SPLIT_LAT - 1);

    state_t            state;
    state_t            state_next;
    logic [7:0]        cnt;
    logic [7:0]        cnt_next;
    logic [DATA_W-1:0] data_q;
    logic              accept;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    assign accept = (state == IDLE) && sel && req_valid;

    // Memory has no reset. It is written only at acceptance, so a read
    // latched at acceptance can never see a later write.
    always_ff @(posedge clk) begin
        if (accept && req_write) begin
            mem[req_addr] <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            data_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept && !req_write) begin
                data_q <= mem[req_addr];
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_write) begin
                        state_next = WACK;
                    end else if (SPLIT_LAT == 0) begin
                        state_next = RFAST;
                    end else begin
                        state_next = SPLIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            WACK:  state_next = IDLE;
            RFAST: state_next = IDLE;
            SPLIT: begin
                // split_grant is deliberately ignored until RESUME.
                if (cnt == 8'd0) begin
                    state_next = RESUME;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            RESUME: begin
                if (split_grant) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // All outputs decode from registered state or data, so no input reaches an
    // output combinationally.
    assign sready = (state == IDLE);
    assign ssplit = (state == SPLIT);
    assign rvalid = (state == RFAST) || (state == RESP);
    assign wack   = (state == WACK);
    assign rdata  = data_q;

endmodule
